// File: rtl/pk_cam_pkg.sv
// Shared types and default sizes for the pk_key_cam account-key CAM.
package pk_cam_pkg;

    localparam int unsigned KEY_W_DEF  = 128;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } cam_state_e;

endpackage

// File: rtl/pk_key_cam_if.sv
// Request/result bundle of pk_key_cam. cam_clear exists only when PK_CAM_CLEAR_EN is defined.
interface pk_key_cam_if #(
    parameter int unsigned KEY_W  = pk_cam_pkg::KEY_W_DEF,
    parameter int unsigned ADDR_W = pk_cam_pkg::ADDR_W_DEF
);
    logic              cam_start;
    logic              cam_write_en;
    logic [ADDR_W-1:0] address;
    logic [KEY_W-1:0]  key_in;
`ifdef PK_CAM_CLEAR_EN
    logic              cam_clear;
`endif
    logic              busy;
    logic              search_done;
    logic              match;
    logic [ADDR_W-1:0] match_addr;
    logic [ADDR_W:0]   entry_count;

    modport master (
`ifdef PK_CAM_CLEAR_EN
        output cam_clear,
`endif
        output cam_start, cam_write_en, address, key_in,
        input  busy, search_done, match, match_addr, entry_count
    );

    modport slave (
`ifdef PK_CAM_CLEAR_EN
        input  cam_clear,
`endif
        input  cam_start, cam_write_en, address, key_in,
        output busy, search_done, match, match_addr, entry_count
    );

endinterface

// File: rtl/pk_key_cam.sv
// Sequential-search key CAM: one entry compared per cycle, lowest hit index wins.
// Optional PK_CAM_CLEAR_EN adds a bulk invalidate (cam_clear) that also forces a miss.
module pk_key_cam
    import pk_cam_pkg::*;
#(
    parameter int unsigned KEY_W  = KEY_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input logic             clk,
    input logic             rst,
    pk_key_cam_if.slave     cam_if
);

    localparam int unsigned Depth  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   CntOne = 1;
    localparam logic [ADDR_W-1:0] IdxOne = 1;

    logic [KEY_W-1:0]  key_mem_q [Depth];
    logic [KEY_W-1:0]  skey_q;
    logic [Depth-1:0]  valid_q, valid_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] match_addr_q, match_addr_d;
    logic              match_q, match_d;
    logic              done_q, done_d;
    logic              load_key;
    logic              entry_hit;
    logic              clear;
    cam_state_e        state_q, state_d;

`ifdef PK_CAM_CLEAR_EN
    assign clear = cam_if.cam_clear;
`else
    assign clear = 1'b0;
`endif

    // Compares registered contents, so a same-cycle write to this entry is not seen.
    assign entry_hit = valid_q[idx_q] && (key_mem_q[idx_q] == skey_q);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        match_d      = match_q;
        match_addr_d = match_addr_q;
        done_d       = 1'b0;
        load_key     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cam_if.cam_start) begin
                    load_key = 1'b1;
                    idx_d    = '0;
                    state_d  = StSearch;
                end
            end
            StSearch: begin
                if (clear) begin
                    match_d      = 1'b0;
                    match_addr_d = '0;
                    state_d      = StDone;
                end else if (entry_hit) begin
                    match_d      = 1'b1;
                    match_addr_d = idx_q;
                    state_d      = StDone;
                end else if (&idx_q) begin
                    match_d      = 1'b0;
                    match_addr_d = '0;
                    state_d      = StDone;
                end else begin
                    idx_d = idx_q + IdxOne;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (clear) begin
            valid_d = '0;
            count_d = '0;
        end else if (cam_if.cam_write_en) begin
            if (!valid_q[cam_if.address]) begin
                count_d = count_q + CntOne;
            end
            valid_d[cam_if.address] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            match_q      <= 1'b0;
            match_addr_q <= '0;
            done_q       <= 1'b0;
            valid_q      <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            match_q      <= match_d;
            match_addr_q <= match_addr_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
        end
    end

    // Key storage and search key carry no reset; validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (load_key) begin
            skey_q <= cam_if.key_in;
        end
        if (cam_if.cam_write_en) begin
            key_mem_q[cam_if.address] <= cam_if.key_in;
        end
    end

    assign cam_if.busy        = (state_q != StIdle);
    assign cam_if.search_done = done_q;
    assign cam_if.match       = match_q;
    assign cam_if.match_addr  = match_addr_q;
    assign cam_if.entry_count = count_q;

endmodule

// File: tb/tb_pk_key_cam.sv
// Scoreboard bench for pk_key_cam: directed cases plus randomized writes/searches vs a table model.
module tb_pk_key_cam;
    import pk_cam_pkg::*;

    localparam int unsigned KW    = 128;
    localparam int unsigned AW    = 4;
    localparam int unsigned Depth = 16;

    typedef struct {
        bit match;
        int addr;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    pk_key_cam_if #(.KEY_W(KW), .ADDR_W(AW)) cam_if ();

    pk_key_cam #(.KEY_W(KW), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .cam_if (cam_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain table of keys and valid flags.
    logic [KW-1:0] m_key [Depth];
    bit            m_valid [Depth];
    int            m_count = 0;
    exp_t          sb_q [$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_done_seen = 0;
    int            n_done_exp = 0;
    logic [KW-1:0] pool [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t m_find(input logic [KW-1:0] k);
        exp_t e;
        e.match = 1'b0;
        e.addr  = 0;
        e.cyc   = 0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (m_valid[i] && m_key[i] == k) begin
                e.match = 1'b1;
                e.addr  = i;
            end
        end
        return e;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < Depth; i++) m_valid[i] = 1'b0;
        m_count = 0;
    endtask

    task automatic idle_inputs();
        cam_if.cam_start    = 1'b0;
        cam_if.cam_write_en = 1'b0;
        cam_if.address      = '0;
        cam_if.key_in       = '0;
`ifdef PK_CAM_CLEAR_EN
        cam_if.cam_clear    = 1'b0;
`endif
    endtask

    // Drives one cycle of stimulus; returns at the negedge after the sampling edge.
    task automatic do_op(input bit start, input bit we, input int wa, input logic [KW-1:0] key,
                         input bit clr, input bit accept);
        exp_t e;
        int   e_edge;
        @(negedge clk);
        cam_if.cam_start    = start;
        cam_if.cam_write_en = we;
        cam_if.address      = wa[AW-1:0];
        cam_if.key_in       = key;
`ifdef PK_CAM_CLEAR_EN
        cam_if.cam_clear    = clr;
`endif
        if (clr) begin
            m_clear();
        end else if (we) begin
            if (!m_valid[wa]) m_count++;
            m_valid[wa] = 1'b1;
            m_key[wa]   = key;
        end
        if (start && accept) begin
            e      = m_find(key);
            e_edge = cyc + 1;
            e.cyc  = e.match ? e_edge + e.addr + 2 : e_edge + Depth + 1;
            sb_q.push_back(e);
            n_done_exp++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || cam_if.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: no search_done within %0d cycles, %0d pending", n, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && cam_if.search_done) begin
            n_done_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_search_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("match", 64'(cam_if.match), 64'(e.match));
                check("match_addr", 64'(cam_if.match_addr), 64'(e.addr));
                if (e.cyc >= 0) check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        exp_t e;
        int   r;
        int   wa;
        logic [KW-1:0] k;

        idle_inputs();
        for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < Depth; i++) m_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(cam_if.busy), 64'd0);
        check("reset_done", 64'(cam_if.search_done), 64'd0);
        check("reset_match", 64'(cam_if.match), 64'd0);
        check("reset_match_addr", 64'(cam_if.match_addr), 64'd0);
        check("reset_count", 64'(cam_if.entry_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Empty CAM miss.
        do_op(1, 0, 0, 128'hA5, 0, 1);
        check("busy_in_search", 64'(cam_if.busy), 64'd1);
        wait_idle();
        check("count_empty", 64'(cam_if.entry_count), 64'd0);

        // Single entry hit.
        do_op(0, 1, 3, 128'h11, 0, 0);
        do_op(1, 0, 0, 128'h11, 0, 1);
        wait_idle();
        check("count_one", 64'(cam_if.entry_count), 64'(m_count));

        // Lowest index wins; rewrite keeps count.
        do_op(0, 1, 7, 128'h22, 0, 0);
        do_op(0, 1, 2, 128'h22, 0, 0);
        do_op(1, 0, 0, 128'h22, 0, 1);
        wait_idle();
        check("count_three", 64'(cam_if.entry_count), 64'd3);
        do_op(0, 1, 2, 128'h33, 0, 0);
        check("count_rewrite", 64'(cam_if.entry_count), 64'd3);
        do_op(1, 0, 0, 128'h22, 0, 1);
        wait_idle();
        check("match_held", 64'(cam_if.match_addr), 64'd7);

        // Start while busy is ignored.
        do_op(1, 0, 0, 128'hDEAD, 0, 1);
        repeat (2) @(negedge clk);
        do_op(1, 0, 0, 128'h11, 0, 0);
        wait_idle();
        repeat (5) @(negedge clk);
        check("single_done_pulse", 64'(n_done_seen), 64'(n_done_exp));

        // Same-cycle write to the compared entry and write to a passed entry.
        do_op(0, 1, 6, 128'h44, 0, 0);
        do_op(1, 0, 0, 128'h44, 0, 1);
        repeat (5) @(negedge clk);
        do_op(0, 1, 6, 128'h45, 0, 0);
        wait_idle();
        do_op(0, 1, 9, 128'h55, 0, 0);
        do_op(1, 0, 0, 128'h55, 0, 1);
        repeat (4) @(negedge clk);
        do_op(0, 1, 0, 128'h55, 0, 0);
        wait_idle();

        // Start with a simultaneous write sees the new entry.
        do_op(1, 1, 12, 128'h66, 0, 1);
        wait_idle();
        check("count_start_write", 64'(cam_if.entry_count), 64'(m_count));

        // Asynchronous reset mid-search.
        do_op(1, 0, 0, 128'hBEEF, 0, 1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 64'(cam_if.busy), 64'd0);
        check("rst_done", 64'(cam_if.search_done), 64'd0);
        check("rst_count", 64'(cam_if.entry_count), 64'd0);
        m_clear();
        sb_q.delete();
        n_done_exp--;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_done", 64'(n_done_seen), 64'(n_done_exp));
        do_op(1, 0, 0, 128'h11, 0, 1);
        wait_idle();

        // Randomized writes and searches.
        for (int it = 0; it < 60; it++) begin
            r  = $urandom_range(0, 4);
            wa = $urandom_range(0, Depth - 1);
            k  = pool[$urandom_range(0, 5)];
            if (r <= 1) begin
                do_op(0, 1, wa, k, 0, 0);
            end else if (r == 2) begin
                do_op(1, 0, 0, k, 0, 1);
                wait_idle();
            end else if (r == 3) begin
                do_op(1, 1, wa, k, 0, 1);
                wait_idle();
            end else begin
                do_op(1, 0, 0, {$urandom, $urandom, $urandom, $urandom}, 0, 1);
                wait_idle();
            end
            check("rand_count", 64'(cam_if.entry_count), 64'(m_count));
        end

`ifdef PK_CAM_CLEAR_EN
        for (int i = 0; i < Depth; i++) do_op(0, 1, i, 128'h100 + 128'(i), 0, 0);
        check("count_full", 64'(cam_if.entry_count), 64'd16);
        do_op(0, 1, 5, 128'h77, 1, 0);
        check("count_cleared", 64'(cam_if.entry_count), 64'd0);
        do_op(1, 0, 0, 128'h77, 0, 1);
        wait_idle();
        // Clear during a search that would otherwise hit at index 10.
        do_op(0, 1, 10, 128'h88, 0, 0);
        do_op(1, 0, 0, 128'h88, 0, 1);
        e       = sb_q.pop_back();
        e.match = 1'b0;
        e.addr  = 0;
        e.cyc   = -1;
        sb_q.push_back(e);
        repeat (2) @(negedge clk);
        do_op(0, 0, 0, 128'h0, 1, 0);
        wait_idle();
        check("count_clear_search", 64'(cam_if.entry_count), 64'd0);
`endif

        repeat (5) @(negedge clk);
        check("total_done_pulses", 64'(n_done_seen), 64'(n_done_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
